// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: control inputs, imem address/data and the IF/ID register outputs.
// master = fetch unit, slave = pipeline/memory environment.
interface fetch_unit_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] ir;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_pc, ir,
        output pc_out, id_valid, id_pc, id_inst, halted, misaligned, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, ir,
        input  pc_out, id_valid, id_pc, id_inst, halted, misaligned, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, IF/ID register, redirect/halt handling, fetch counter.
// Latency: ir for pc_out before an edge appears on id_inst/id_pc after that edge.
// Backpressure: stall holds PC and IF/ID; a redirect overrides stall.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] HALT_INST  = 32'h0010_0073,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1) & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        id_valid_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_inst_q;
    logic        halted_q;
    logic        misaligned_q;
    logic [31:0] fetch_count_q;

    logic [31:0] pc_redir_d;
    logic [31:0] pc_inc_d;
    logic        redir_misaligned_d;

    // Redirect target is word-aligned and wrapped into the imem address range.
    assign pc_redir_d         = {bus.redirect_pc[31:2], 2'b00} & PC_MASK;
    assign pc_inc_d           = (pc_q + 32'd4) & PC_MASK;
    assign redir_misaligned_d = |bus.redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'd0;
            id_inst_q     <= NOP_INST;
            halted_q      <= 1'b0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else if (bus.redirect_valid) begin
            // Same flush from every state; it also releases HALT.
            state_q    <= RUN;
            pc_q       <= pc_redir_d;
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
            halted_q   <= 1'b0;
            if (redir_misaligned_d) begin
                misaligned_q <= 1'b1;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (!bus.stall) begin
                        id_inst_q     <= bus.ir;
                        id_pc_q       <= pc_q;
                        id_valid_q    <= 1'b1;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        if (bus.ir == HALT_INST) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            pc_q <= pc_inc_d;
                        end
                    end
                end
                HALT: begin
                    // The halt instruction is handed to decode exactly once.
                    if (!bus.stall) begin
                        id_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_inst     = id_inst_q;
    assign bus.halted      = halted_q;
    assign bus.misaligned  = misaligned_q;
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational 256-word instruction memory model.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [31:0] imem [256];

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (256),
        .HALT_INST  (32'h0010_0073),
        .NOP_INST   (32'h0000_0013)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    assign bus.ir = imem[bus.pc_out[9:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        imem[0] = 32'h0000_0093;
        imem[1] = 32'h0010_0113;
        imem[2] = 32'h0020_0193;
        imem[3] = 32'h0030_0213;
        imem[4] = 32'h0010_0073;

        rst_n              = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        tick();
        tick();
        chk("rst_pc",       bus.pc_out,      32'h0);
        chk("rst_valid",    32'(bus.id_valid), 32'd0);
        chk("rst_id_pc",    bus.id_pc,       32'h0);
        chk("rst_inst",     bus.id_inst,     32'h0000_0013);
        chk("rst_halted",   32'(bus.halted), 32'd0);
        chk("rst_misal",    32'(bus.misaligned), 32'd0);
        chk("rst_count",    bus.fetch_count, 32'd0);
        rst_n = 1'b1;

        // BOOT cycle: nothing captured.
        tick();
        chk("boot_valid", 32'(bus.id_valid), 32'd0);
        chk("boot_pc",    bus.pc_out,        32'h0);

        tick();
        chk("run0_pc",   bus.id_pc,   32'h0);
        chk("run0_inst", bus.id_inst, 32'h0000_0093);
        chk("run0_vld",  32'(bus.id_valid), 32'd1);
        tick();
        chk("run1_pc",   bus.id_pc,   32'h4);
        chk("run1_inst", bus.id_inst, 32'h0010_0113);
        tick();
        chk("run2_pc",   bus.id_pc,   32'h8);
        chk("run2_inst", bus.id_inst, 32'h0020_0193);
        chk("run2_cnt",  bus.fetch_count, 32'd3);

        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_id_pc", bus.id_pc,       32'h8);
            chk("stall_inst",  bus.id_inst,     32'h0020_0193);
            chk("stall_pc",    bus.pc_out,      32'hC);
            chk("stall_cnt",   bus.fetch_count, 32'd3);
        end
        bus.stall = 1'b0;
        tick();
        chk("rel_id_pc", bus.id_pc,       32'hC);
        chk("rel_inst",  bus.id_inst,     32'h0030_0213);
        chk("rel_cnt",   bus.fetch_count, 32'd4);

        tick();
        chk("halt_inst",  bus.id_inst,        32'h0010_0073);
        chk("halt_vld",   32'(bus.id_valid),  32'd1);
        chk("halt_flag",  32'(bus.halted),    32'd1);
        chk("halt_pc",    bus.pc_out,         32'h10);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("halted_vld",  32'(bus.id_valid), 32'd0);
            chk("halted_flag", 32'(bus.halted),   32'd1);
            chk("halted_pc",   bus.pc_out,        32'h10);
            chk("halted_cnt",  bus.fetch_count,   32'd5);
        end

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        chk("unhalt_flag", 32'(bus.halted),   32'd0);
        chk("unhalt_pc",   bus.pc_out,        32'h0);
        chk("unhalt_vld",  32'(bus.id_valid), 32'd0);
        tick();
        chk("resume_id_pc", bus.id_pc,       32'h0);
        chk("resume_inst",  bus.id_inst,     32'h0000_0093);
        chk("resume_cnt",   bus.fetch_count, 32'd6);

        // Redirect wins over a simultaneous stall.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.stall          = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        chk("rds_vld",  32'(bus.id_valid), 32'd0);
        chk("rds_inst", bus.id_inst,       32'h0000_0013);
        chk("rds_pc",   bus.pc_out,        32'h40);
        tick();
        chk("rds_id_pc", bus.id_pc,       32'h40);
        chk("rds_cnt",   bus.fetch_count, 32'd7);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h22;
        tick();
        chk("mis_pc",   bus.pc_out,          32'h20);
        chk("mis_flag", 32'(bus.misaligned), 32'd1);
        bus.redirect_pc = 32'h3FC;
        tick();
        bus.redirect_valid = 1'b0;
        chk("mis_sticky", 32'(bus.misaligned), 32'd1);
        chk("wrap_pre",   bus.pc_out,          32'h3FC);
        tick();
        chk("wrap_pc",    bus.pc_out,          32'h0);
        chk("wrap_id_pc", bus.id_pc,           32'h3FC);
        chk("wrap_cnt",   bus.fetch_count,     32'd8);
        chk("wrap_misal", 32'(bus.misaligned), 32'd1);
        tick();
        tick();

        // Asynchronous reset mid-stream, sampled between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",    bus.pc_out,          32'h0);
        chk("arst_vld",   32'(bus.id_valid),   32'd0);
        chk("arst_cnt",   bus.fetch_count,     32'd0);
        chk("arst_misal", 32'(bus.misaligned), 32'd0);
        chk("arst_inst",  bus.id_inst,         32'h0000_0013);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the single-cycle/pipelined CPU.
- Owns the program counter and drives pc_out to the combinational instruction memory (word index = pc_out/4, 256 words).
- Captures the returned ir into the IF/ID pipeline register for the decoder.
- Handles stall, redirect (branch/jump flush), halt detection and a fetched-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word aligned.
IMEM_DEPTH, 256, instruction memory depth in words; power of two; PC wraps modulo IMEM_DEPTH*4.
HALT_INST, 32'h0010_0073, encoding that stops fetch (ebreak).
NOP_INST, 32'h0000_0013, value loaded into id_inst on reset/flush.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  decoder cannot accept; hold PC and IF/ID.
redirect_valid  input  1  branch/jump taken; load redirect_pc and flush IF/ID.
redirect_pc  input  32  redirect target address.
pc_out  output  32  fetch address to instruction memory.
ir  input  32  instruction word returned combinationally for pc_out.
id_valid  output  1  IF/ID holds a valid instruction.
id_pc  output  32  address of id_inst.
id_inst  output  32  instruction delivered to decode.
halted  output  1  fetch stopped on HALT_INST.
misaligned  output  1  sticky: a redirect_pc with nonzero bits [1:0] was received.
fetch_count  output  32  number of instructions written into IF/ID with valid=1; wraps at 2^32.

Behaviour:
- Reset (rst_n=0, async):
  - pc_out=RESET_PC; id_valid=0; id_pc=0; id_inst=NOP_INST.
  - halted=0; misaligned=0; fetch_count=0; state=BOOT.
- All other updates occur on the rising edge of clk.
- States:
  - BOOT: one cycle after reset deassertion; no capture, PC unchanged, id_valid=0. Goes to RUN. A redirect in BOOT is applied as in RUN, then the FSM goes to RUN.
  - RUN: priority per cycle is redirect > stall > normal.
    - Redirect: pc_out <= {redirect_pc[31:2],2'b00} mod IMEM_DEPTH*4. id_valid<=0. id_inst<=NOP_INST. If redirect_pc[1:0]!=0, set misaligned. Redirect overrides a simultaneous stall. No count increment.
    - Stall (no redirect): pc_out, id_valid, id_pc, id_inst and fetch_count all hold.
    - Normal: id_inst<=ir; id_pc<=pc_out; id_valid<=1; fetch_count+=1.
      - If ir != HALT_INST: pc_out <= (pc_out+4) mod IMEM_DEPTH*4.
      - If ir == HALT_INST: pc_out holds, halted<=1, state<=HALT.
  - HALT: pc_out holds.
    - Without stall: id_valid<=0 on the next cycle (the halt instruction is consumed once); no further captures.
    - With stall: IF/ID holds.
    - A redirect leaves HALT: apply the redirect as in RUN, halted<=0, state<=RUN.
- Latency: the ir addressed by pc_out before edge N is visible on id_inst/id_pc after edge N. Throughput is one instruction per cycle when not stalled.
- Wrap: pc_out = IMEM_DEPTH*4-4 followed by a normal cycle gives pc_out = 0. No error is raised.
- pc_out[1:0] is always 0.
- misaligned clears only on reset.
- Reset asserted mid-operation (any state, including a stalled or halted one) returns all outputs immediately to their reset values.

Test Plan:
- Reset then free run with memory words 0..3 = 0x00000093, 0x00100113, 0x00200193, 0x00300213, no stall → after BOOT, successive cycles give id_pc 0,4,8,12 with matching id_inst, id_valid=1; fetch_count=4 after 4 captures.
- Stall held 3 cycles while id_pc=8 → id_pc=8, id_inst and pc_out=12 unchanged for 3 cycles; fetch_count unchanged. On release, next id_pc=12.
- redirect_valid with redirect_pc=0x40 together with stall=1 → next cycle id_valid=0, id_inst=0x00000013, pc_out=0x40. The following cycle gives id_pc=0x40.
- redirect_pc=0x22 → pc_out=0x20, misaligned=1, and misaligned stays 1 through later redirects until rst_n=0.
- Word at 0x10 = 0x00100073 → id_inst=0x00100073 with id_valid=1 for one cycle, then id_valid=0, halted=1, pc_out=0x10 stable. A redirect to 0x0 clears halted and fetch resumes at 0.
- PC at 0x3FC with IMEM_DEPTH=256, normal cycle → pc_out=0x000. Asserting rst_n=0 mid-stream → pc_out=RESET_PC, id_valid=0, fetch_count=0 asynchronously, without waiting for a clock edge.
